mm_line_packer: RTL

MM_LINE_PACKER -- requirements
Module: mm_line_packer

---
 rtl/mm_line_packer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mm_line_packer.sv
// mm_line_packer
//   Gathers scalar CPU stores into one 32-byte line buffer. The line is
//   written to memory in a single cycle when it becomes full, when flush is
//   requested, or when a store to a different line arrives. Bytes the CPU
//   never wrote are taken from the current memory contents (mm_drdata).
//
// Ports
//   clk        : single clock, rising edge
//   reset      : asynchronous, active-high
//   daddr      : store byte address (line = [31:5], word = [4:2])
//   dwdata     : store data, byte lane i = dwdata[8i+7:8i]
//   dwe        : per-byte write enables, nonzero = store request
//   flush      : drain a partially filled line
//   stall      : CPU must hold daddr/dwdata/dwe while high
//   mm_daddr   : 32-byte-aligned base of the line being drained
//   mm_drdata  : current memory contents at mm_daddr (combinational read)
//   mm_dwdata  : merged line write data (zero outside a drain)
//   mm_dwe     : line write strobe, one cycle per drain
//
// Build option
//   MM_LINE_PACKER_AUTOFLUSH_EN : when defined, a partial line that sees no
//   accepted store drains by itself; mm_dwe rises in the 16th idle cycle.
//
// State | Meaning
// IDLE  | no pending bytes
// FILL  | at least one pending byte in the line buffer
// DRAIN | line write issued this cycle (mm_dwe=1)

module mm_line_packer (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  daddr,
  input  logic [31:0]  dwdata,
  input  logic [3:0]   dwe,
  input  logic         flush,
  output logic         stall,
  output logic [31:0]  mm_daddr,
  input  logic [255:0] mm_drdata,
  output logic [255:0] mm_dwdata,
  output logic         mm_dwe
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nxt;

  logic [26:0]  base_q;
  logic [255:0] line_q;
  logic [31:0]  mask_q;

  logic         store_req;
  logic         same_line;
  logic         conflict;
  logic         accept;
  logic         full_next;
  logic         timeout;
  logic [31:0]  store_mask;
  logic [255:0] store_data;
  logic [255:0] store_bits;
  logic [255:0] mask_bits;
  logic         addr_lsb_unused;

  assign store_req  = |dwe;
  assign same_line  = (daddr[31:5] == base_q);
  assign conflict   = (state == FILL) && store_req && !same_line;
  assign accept     = store_req && ((state == IDLE) || ((state == FILL) && same_line));

  // Byte lanes of the store placed at their position within the 32-byte line.
  assign store_mask = 32'(dwe) << {daddr[4:2], 2'b00};
  assign store_data = 256'(dwdata) << {daddr[4:2], 5'b00000};

  // Full detection includes the store arriving this cycle.
  assign full_next  = &(mask_q | store_mask);

  // Stores are word-addressed; the byte offset carries no information.
  assign addr_lsb_unused = ^daddr[1:0];

  always_comb begin
    store_bits = '0;
    mask_bits  = '0;
    for (int b = 0; b < 32; b++) begin
      store_bits[8*b +: 8] = {8{store_mask[b]}};
      mask_bits[8*b +: 8]  = {8{mask_q[b]}};
    end
  end

`ifdef MM_LINE_PACKER_AUTOFLUSH_EN
  logic [3:0] idle_cnt;

  // Counts FILL cycles without an accepted store; value k-1 in the k-th one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if ((state != FILL) || accept) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 4'd1;
    end
  end

  // The 15th idle cycle brings the count to 15; DRAIN follows on that edge
  // so the strobe lands in the 16th idle cycle.
  assign timeout = (state == FILL) && !accept && (idle_cnt == 4'd14);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    mm_dwe    = 1'b0;
    case (state)
      IDLE: begin
        if (store_req) begin
          state_nxt = FILL;
        end
      end
      FILL: begin
        // A conflicting store is held off and the current line drains first.
        if (conflict) begin
          stall     = 1'b1;
          state_nxt = DRAIN;
        end else if (flush || timeout || (accept && full_next)) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        stall     = 1'b1;
        mm_dwe    = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q <= '0;
      line_q <= '0;
      mask_q <= '0;
    end else if (accept) begin
      if (state == IDLE) begin
        base_q <= daddr[31:5];
      end
      line_q <= (line_q & ~store_bits) | (store_data & store_bits);
      mask_q <= mask_q | store_mask;
    end else if (state == DRAIN) begin
      mask_q <= '0;
    end
  end

  assign mm_daddr  = (state == DRAIN) ? {base_q, 5'b00000} : 32'd0;
  assign mm_dwdata = (state == DRAIN) ? ((line_q & mask_bits) | (mm_drdata & ~mask_bits))
                                      : 256'd0;

endmodule
